// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and PC-redirect controller for the RV32 pipeline.
// Optional feature macro: HAZARD_X0_FILTER_EN (source register x0 never
// matches the EX load destination, so loads to x0 never stall).
// Outputs are combinational from the state and current inputs so that
// stalls and redirects act in the cycle they are detected.
module hazard_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned LOAD_STALL  = 1,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_vld,
  input  logic              id_jmp_vld,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              ex_jmp_vld,
  input  logic [XLEN-1:0]   ex_jmp_addr,
  output logic              hold_if,
  output logic              jmp_vld_if,
  output logic [XLEN-1:0]   jmp_addr_if,
  output logic              flush_id,
  output logic              inst_vld_ex
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_DEPTH - 1);
  localparam bit STALL_ONE = (LOAD_STALL == 1);
  localparam bit FLUSH_ONE = (FLUSH_DEPTH == 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rs1_hit, rs2_hit, hz;

  // Source-register match against the load destination in EX
`ifdef HAZARD_X0_FILTER_EN
  assign rs1_hit = id_rs1_used && (id_rs1 == ex_rd) && (id_rs1 != '0);
  assign rs2_hit = id_rs2_used && (id_rs2 == ex_rd) && (id_rs2 != '0);
`else
  assign rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_hit = id_rs2_used && (id_rs2 == ex_rd);
`endif

  assign hz = ex_vld && ex_is_load && (rs1_hit || rs2_hit);

  // State and bubble counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and output decode; EX redirect outranks everything
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hold_if     = 1'b0;
    jmp_vld_if  = 1'b0;
    jmp_addr_if = '0;
    flush_id    = 1'b0;
    inst_vld_ex = 1'b0;

    if (ex_jmp_vld) begin
      jmp_vld_if  = 1'b1;
      jmp_addr_if = ex_jmp_addr;
      flush_id    = 1'b1;
      if (FLUSH_ONE) begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end else begin
        state_nxt = FLUSH;
        cnt_nxt   = FLUSH_INIT;
      end
    end else begin
      case (state)
        RUN: begin
          if (hz) begin
            hold_if = 1'b1;
            if (STALL_ONE) begin
              state_nxt = RUN;
              cnt_nxt   = '0;
            end else begin
              state_nxt = STALL;
              cnt_nxt   = STALL_INIT;
            end
          end else if (id_jmp_vld) begin
            jmp_vld_if  = 1'b1;
            jmp_addr_if = id_pc + id_imm;
            flush_id    = 1'b1;
            inst_vld_ex = 1'b1;
          end else begin
            inst_vld_ex = 1'b1;
          end
        end
        STALL: begin
          hold_if = 1'b1;
          if (cnt <= CNT_W'(1)) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        FLUSH: begin
          if (cnt <= CNT_W'(1)) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end

    // Quiet outputs for as long as reset is held
    if (rst) begin
      hold_if     = 1'b0;
      jmp_vld_if  = 1'b0;
      jmp_addr_if = '0;
      flush_id    = 1'b0;
      inst_vld_ex = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances share stimulus,
// A with LOAD_STALL=2/FLUSH_DEPTH=3, B with LOAD_STALL=3/FLUSH_DEPTH=1.
module tb_hazard_ctrl;

  typedef struct packed {
    logic        hold;
    logic        jv;
    logic [31:0] addr;
    logic        flush;
    logic        vld;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_is_load, ex_vld;
  logic        id_jmp_vld, ex_jmp_vld;
  logic [31:0] id_imm, id_pc, ex_jmp_addr;

  logic        a_hold, a_jv, a_flush, a_vld;
  logic [31:0] a_addr;
  logic        b_hold, b_jv, b_flush, b_vld;
  logic [31:0] b_addr;

  int checks = 0;
  int errors = 0;

  exp_t  q_a[$];
  exp_t  q_b[$];
  string q_tag[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.XLEN(32), .REG_AW(5), .LOAD_STALL(2), .FLUSH_DEPTH(3)) u_a (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_vld(ex_vld),
    .id_jmp_vld(id_jmp_vld), .id_imm(id_imm), .id_pc(id_pc),
    .ex_jmp_vld(ex_jmp_vld), .ex_jmp_addr(ex_jmp_addr),
    .hold_if(a_hold), .jmp_vld_if(a_jv), .jmp_addr_if(a_addr),
    .flush_id(a_flush), .inst_vld_ex(a_vld)
  );

  hazard_ctrl #(.XLEN(32), .REG_AW(5), .LOAD_STALL(3), .FLUSH_DEPTH(1)) u_b (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_vld(ex_vld),
    .id_jmp_vld(id_jmp_vld), .id_imm(id_imm), .id_pc(id_pc),
    .ex_jmp_vld(ex_jmp_vld), .ex_jmp_addr(ex_jmp_addr),
    .hold_if(b_hold), .jmp_vld_if(b_jv), .jmp_addr_if(b_addr),
    .flush_id(b_flush), .inst_vld_ex(b_vld)
  );

  // Expected-output shorthands: {hold, jmp_vld, addr, flush, inst_vld_ex}
  function automatic exp_t e_idle();     return '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1}; endfunction
  function automatic exp_t e_hold();     return '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0}; endfunction
  function automatic exp_t e_dead();     return '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0}; endfunction
  function automatic exp_t e_exj(input logic [31:0] a); return '{1'b0, 1'b1, a, 1'b1, 1'b0}; endfunction
  function automatic exp_t e_idj(input logic [31:0] a); return '{1'b0, 1'b1, a, 1'b1, 1'b1}; endfunction

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_is_load = 1'b0; ex_vld = 1'b0;
    id_jmp_vld = 1'b0; ex_jmp_vld = 1'b0;
    id_imm = 32'h0; id_pc = 32'h0; ex_jmp_addr = 32'h0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2);
    ex_vld = 1'b1; ex_is_load = 1'b1; ex_rd = rd;
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
  endtask

  // Push this cycle's expectations, compare at the falling edge, advance a cycle
  task automatic step(input string tag, input exp_t ea, input exp_t eb);
    exp_t  xa, xb, ga, gb;
    string t;
    q_a.push_back(ea);
    q_b.push_back(eb);
    q_tag.push_back(tag);
    @(negedge clk);
    xa = q_a.pop_front();
    xb = q_b.pop_front();
    t  = q_tag.pop_front();
    ga = '{a_hold, a_jv, a_addr, a_flush, a_vld};
    gb = '{b_hold, b_jv, b_addr, b_flush, b_vld};
    checks++;
    assert (ga === xa) else begin
      errors++;
      $error("FAIL %s/A observed hold=%b jv=%b addr=%h flush=%b vld=%b expected hold=%b jv=%b addr=%h flush=%b vld=%b",
             t, ga.hold, ga.jv, ga.addr, ga.flush, ga.vld, xa.hold, xa.jv, xa.addr, xa.flush, xa.vld);
    end
    checks++;
    assert (gb === xb) else begin
      errors++;
      $error("FAIL %s/B observed hold=%b jv=%b addr=%h flush=%b vld=%b expected hold=%b jv=%b addr=%h flush=%b vld=%b",
             t, gb.hold, gb.jv, gb.addr, gb.flush, gb.vld, xb.hold, xb.jv, xb.addr, xb.flush, xb.vld);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    ex_jmp_vld = 1'b1; ex_jmp_addr = 32'hDEAD_BEEF;
    step("reset_quiet", e_dead(), e_dead());
    clear_inputs();
    rst = 1'b0;
    step("post_reset_idle", e_idle(), e_idle());

    // load-use with a jump waiting in ID: jump held off until the stall ends
    set_load_use(5'd5, 5'd5, 1'b1, 5'd1, 1'b0);
    id_jmp_vld = 1'b1; id_pc = 32'h0000_1000; id_imm = 32'h4;
    step("lu_detect", e_hold(), e_hold());
    ex_vld = 1'b0; ex_is_load = 1'b0;
    step("lu_stall2", e_hold(), e_hold());
    step("lu_end_a_jump", e_idj(32'h0000_1004), e_hold());
    id_jmp_vld = 1'b0;
    step("lu_after", e_idle(), e_idle());

    // jump target wrap-around
    clear_inputs();
    id_jmp_vld = 1'b1; id_pc = 32'hFFFF_FFF0; id_imm = 32'h20;
    step("jmp_wrap", e_idj(32'h10), e_idj(32'h10));

    // EX redirect; ID jumps on the wrong path must not redirect on A
    clear_inputs();
    ex_jmp_vld = 1'b1; ex_jmp_addr = 32'h100;
    step("exj_redirect", e_exj(32'h100), e_exj(32'h100));
    clear_inputs();
    id_jmp_vld = 1'b1; id_pc = 32'h2000; id_imm = 32'h8;
    step("exj_flush2", e_dead(), e_idj(32'h2008));
    step("exj_flush3", e_dead(), e_idj(32'h2008));
    step("exj_done", e_idj(32'h2008), e_idj(32'h2008));
    clear_inputs();
    step("exj_idle", e_idle(), e_idle());

    // simultaneous hazard and EX redirect: redirect only
    set_load_use(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
    ex_jmp_vld = 1'b1; ex_jmp_addr = 32'h200;
    step("hz_and_exj", e_exj(32'h200), e_exj(32'h200));
    clear_inputs();
    step("hz_exj_f2", e_dead(), e_idle());
    step("hz_exj_f3", e_dead(), e_idle());
    step("hz_exj_idle", e_idle(), e_idle());

    // EX redirect while stalled aborts the stall
    set_load_use(5'd3, 5'd1, 1'b0, 5'd3, 1'b1);
    step("stall_detect", e_hold(), e_hold());
    clear_inputs();
    ex_jmp_vld = 1'b1; ex_jmp_addr = 32'h300;
    step("stall_abort", e_exj(32'h300), e_exj(32'h300));
    clear_inputs();
    step("abort_f2", e_dead(), e_idle());
    step("abort_f3", e_dead(), e_idle());
    step("abort_idle", e_idle(), e_idle());

    // load to x0 with rs2=x0 used
    set_load_use(5'd0, 5'd7, 1'b0, 5'd0, 1'b1);
`ifdef HAZARD_X0_FILTER_EN
    step("x0_detect", e_idle(), e_idle());
    clear_inputs();
    step("x0_c2", e_idle(), e_idle());
    step("x0_c3", e_idle(), e_idle());
`else
    step("x0_detect", e_hold(), e_hold());
    clear_inputs();
    step("x0_c2", e_hold(), e_hold());
    step("x0_c3", e_idle(), e_hold());
`endif
    step("x0_idle", e_idle(), e_idle());

    // rs1 matches but is not read: no hazard
    set_load_use(5'd9, 5'd9, 1'b0, 5'd3, 1'b1);
    step("rs1_unused", e_idle(), e_idle());
    clear_inputs();

    // reset in the middle of a flush
    ex_jmp_vld = 1'b1; ex_jmp_addr = 32'h400;
    step("rf_redirect", e_exj(32'h400), e_exj(32'h400));
    clear_inputs();
    step("rf_flush2", e_dead(), e_idle());
    rst = 1'b1;
    step("rf_in_reset", e_dead(), e_dead());
    rst = 1'b0;
    step("rf_release", e_idle(), e_idle());
    step("rf_idle", e_idle(), e_idle());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
